vga_sync_monitor: RTL and testbench

Receive-side counterpart to the VGA timing generator: samples `h_sync`/`v_sync` in the pixel clock domain and measures line length, sync width and lines per frame. It checks these against the expected timing and declares lock after consecutive good frames. Once locked, it regenerates pixel coordinates and an active-area flag. It sits on the monitor/loopback side of the display path and feeds the frame checker and capture logic.

---
 rtl/vga_sync_monitor_if.sv | 24 ++
 rtl/vga_sync_monitor.sv | 187 ++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_monitor_if.sv
// Sync inputs and measurement outputs of the VGA sync monitor.
// master drives the syncs (source / loopback side); slave is the monitor.
interface vga_sync_monitor_if;
  logic        h_sync;
  logic        v_sync;
  logic        locked;
  logic        active;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;
  logic        h_err;
  logic        v_err;

  modport master (
    output h_sync, v_sync,
    input  locked, active, pix_x, pix_y, line_len, frame_lines, h_err, v_err
  );

  modport slave (
    input  h_sync, v_sync,
    output locked, active, pix_x, pix_y, line_len, frame_lines, h_err, v_err
  );
endinterface

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: measures h/v sync timing, declares lock after
// consecutive good frames and regenerates pixel coordinates while locked.
module vga_sync_monitor #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_TOTAL     = 521,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 29,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic              clk_25,
  input  logic              reset_n,
  vga_sync_monitor_if.slave bus
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_e;

  localparam logic [11:0] H_TOTAL_L = 12'(H_TOTAL);
  localparam logic [10:0] H_SYNC_L  = 11'(H_SYNC);
  localparam logic [10:0] H_START_L = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END_L   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  V_TOTAL_L = 10'(V_TOTAL);
  localparam logic [9:0]  V_START_L = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END_L   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [7:0]  LOCK_L    = 8'(LOCK_FRAMES);

  logic        h_d_q, v_d_q;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] hs_w_q, hs_w_d;
  logic        h_seen_q, h_seen_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        frame_bad_q, frame_bad_d;
  logic [7:0]  good_q, good_d;
  state_e      state_q, state_d;

  logic        locked_q, locked_d;
  logic        active_q, active_d;
  logic [9:0]  pix_x_q, pix_x_d;
  logic [9:0]  pix_y_q, pix_y_d;
  logic [10:0] line_len_q, line_len_d;
  logic [9:0]  frame_lines_q, frame_lines_d;
  logic        h_err_q, h_err_d;
  logic        v_err_q, v_err_d;

  logic        h_fall, h_rise, v_fall;
  logic [11:0] h_len;
  logic        len_viol, width_viol, h_viol;
  logic        count_ok, frame_ok;
  logic [7:0]  good_inc;

  assign h_fall = h_d_q & ~bus.h_sync;
  assign h_rise = ~h_d_q & bus.h_sync;
  assign v_fall = v_d_q & ~bus.v_sync;

  // Line length is compared one bit wider so a saturated counter cannot alias to H_TOTAL.
  assign h_len      = {1'b0, h_cnt_q} + 12'd1;
  assign len_viol   = h_fall & h_seen_q & (h_len != H_TOTAL_L);
  assign width_viol = h_rise & (hs_w_q != H_SYNC_L);
  assign h_viol     = len_viol | width_viol;

  assign count_ok = (v_cnt_q == V_TOTAL_L);
  assign frame_ok = ~frame_bad_q & count_ok;
  assign good_inc = good_q + 8'd1;

  always_comb begin
    // NOTE: every _d gets a default first so no path through this block can infer a latch.
    h_cnt_d       = h_cnt_q;
    hs_w_d        = hs_w_q;
    h_seen_d      = h_seen_q;
    v_cnt_d       = v_cnt_q;
    good_d        = good_q;
    state_d       = state_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;

    if (h_fall) begin
      h_cnt_d    = '0;
      h_seen_d   = 1'b1;
      line_len_d = h_len[10:0];
    end else if (h_cnt_q != '1) begin
      h_cnt_d = h_cnt_q + 11'd1;
    end

    if (h_fall) begin
      hs_w_d = 11'd1;
    end else if (!bus.h_sync && hs_w_q != '1) begin
      hs_w_d = hs_w_q + 11'd1;
    end

    // A v fall wins over a coincident h fall for the line counter only.
    if (v_fall) begin
      v_cnt_d       = '0;
      frame_lines_d = v_cnt_q;
    end else if (h_fall && v_cnt_q != '1) begin
      v_cnt_d = v_cnt_q + 10'd1;
    end

    frame_bad_d = (v_fall ? 1'b0 : frame_bad_q) | h_viol;

    case (state_q)
      SEARCH: begin
        if (v_fall) begin
          state_d = VERIFY;
          good_d  = '0;
        end
      end
      VERIFY: begin
        if (v_fall) begin
          if (frame_ok) begin
            good_d = good_inc;
            if (good_inc >= LOCK_L) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end
      end
      LOCKED: begin
        if (h_viol || (v_fall && !count_ok)) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase

    h_err_d  = h_viol;
    v_err_d  = v_fall & ~count_ok & (state_q != SEARCH);
    locked_d = (state_d == LOCKED);

    active_d = locked_d
             && (h_cnt_d >= H_START_L) && (h_cnt_d < H_END_L)
             && (v_cnt_d >= V_START_L) && (v_cnt_d < V_END_L);
    pix_x_d  = active_d ? 10'(h_cnt_d - H_START_L) : '0;
    pix_y_d  = active_d ? (v_cnt_d - V_START_L) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      h_d_q         <= 1'b1;
      v_d_q         <= 1'b1;
      h_cnt_q       <= '0;
      hs_w_q        <= '0;
      h_seen_q      <= 1'b0;
      v_cnt_q       <= '0;
      frame_bad_q   <= 1'b0;
      good_q        <= '0;
      state_q       <= SEARCH;
      locked_q      <= 1'b0;
      active_q      <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
    end else begin
      h_d_q         <= bus.h_sync;
      v_d_q         <= bus.v_sync;
      h_cnt_q       <= h_cnt_d;
      hs_w_q        <= hs_w_d;
      h_seen_q      <= h_seen_d;
      v_cnt_q       <= v_cnt_d;
      frame_bad_q   <= frame_bad_d;
      good_q        <= good_d;
      state_q       <= state_d;
      locked_q      <= locked_d;
      active_q      <= active_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      h_err_q       <= h_err_d;
      v_err_q       <= v_err_d;
    end
  end

  assign bus.locked      = locked_q;
  assign bus.active      = active_q;
  assign bus.pix_x       = pix_x_q;
  assign bus.pix_y       = pix_y_q;
  assign bus.line_len    = line_len_q;
  assign bus.frame_lines = frame_lines_q;
  assign bus.h_err       = h_err_q;
  assign bus.v_err       = v_err_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor: directed sync streams, an event/timestamp model of the
// expected outputs checked every cycle, plus hand-computed literal expectations.
module tb_vga_sync_monitor;
  // Horizontal timing at its real values; vertical shrunk so several relocks fit in the run.
  localparam int H_TOTAL = 800, H_SYNC = 96, H_BP = 48, H_ACTIVE = 640;
  localparam int V_TOTAL = 5, V_SYNC = 1, V_BP = 1, V_ACTIVE = 2, LOCK_FRAMES = 2;
  localparam int HS = H_SYNC + H_BP, VS = V_SYNC + V_BP;
  localparam int M_SEARCH = 0, M_VERIFY = 1, M_LOCKED = 2;

  logic clk_25 = 1'b0;
  logic reset_n = 1'b0;
  vga_sync_monitor_if bus();

  always #20 clk_25 = ~clk_25;

  vga_sync_monitor #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE),
    .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk_25 (clk_25),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int probe = 0;
  int cur_line = -1;
  int cur_hc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: h_cnt is edges since the last h fall, v_cnt is h falls since the last v fall.
  int e, h_anchor, low_start, nf, mstate, good;
  bit seen, prev_h, prev_v, fbad;
  bit m_locked, m_active, m_herr, m_verr;
  int m_px, m_py, m_len, m_fl;

  task automatic model_step();
    int hc_prev, hc, vc, old_state;
    bit hs, vs, hf, hr, vf, hv, wrong;
    if (!reset_n) begin
      e = 0; h_anchor = 0; low_start = 0; nf = 0; mstate = M_SEARCH; good = 0;
      seen = 0; prev_h = 1; prev_v = 1; fbad = 0;
      m_locked = 0; m_active = 0; m_herr = 0; m_verr = 0;
      m_px = 0; m_py = 0; m_len = 0; m_fl = 0;
    end else begin
      e++;
      hs = bus.h_sync; vs = bus.v_sync;
      hf = prev_h && !hs; hr = !prev_h && hs; vf = prev_v && !vs;
      prev_h = hs; prev_v = vs;
      hv = 0; wrong = 0;
      hc_prev = (e - 1 - h_anchor > 2047) ? 2047 : e - 1 - h_anchor;
      if (hf) begin
        m_len = (hc_prev + 1) % 2048;
        if (seen && hc_prev + 1 != H_TOTAL) hv = 1;
        seen = 1; h_anchor = e; low_start = e;
      end
      if (hr && (e - low_start) != H_SYNC) hv = 1;
      hc = (e - h_anchor > 2047) ? 2047 : e - h_anchor;
      if (vf) begin
        m_fl = (nf > 1023) ? 1023 : nf;
        wrong = (m_fl != V_TOTAL);
        nf = 0;
      end else if (hf) begin
        nf++;
      end
      vc = (nf > 1023) ? 1023 : nf;
      old_state = mstate;
      if (mstate == M_SEARCH && vf) begin
        mstate = M_VERIFY; good = 0;
      end else if (mstate == M_VERIFY && vf) begin
        if (!fbad && !wrong) begin
          good++;
          if (good == LOCK_FRAMES) mstate = M_LOCKED;
        end else begin
          good = 0;
        end
      end else if (mstate == M_LOCKED && (hv || (vf && wrong))) begin
        mstate = M_SEARCH;
      end
      fbad = (vf ? 1'b0 : fbad) | hv;
      m_herr = hv;
      m_verr = vf && wrong && (old_state != M_SEARCH);
      m_locked = (mstate == M_LOCKED);
      m_active = m_locked && hc >= HS && hc < HS + H_ACTIVE && vc >= VS && vc < VS + V_ACTIVE;
      m_px = m_active ? hc - HS : 0;
      m_py = m_active ? vc - VS : 0;
    end
  endtask

  initial forever begin
    @(posedge clk_25 or negedge reset_n);
    model_step();
  end

  task automatic compare();
    check("locked", bus.locked, m_locked);
    check("active", bus.active, m_active);
    check("pix_x", bus.pix_x, m_px);
    check("pix_y", bus.pix_y, m_py);
    check("line_len", bus.line_len, m_len);
    check("frame_lines", bus.frame_lines, m_fl);
    check("h_err", bus.h_err, m_herr);
    check("v_err", bus.v_err, m_verr);
    case (probe)
      8: begin
        if (cur_line == 0 && cur_hc == 399) check("lock_before_edge", bus.locked, 0);
        if (cur_line == 0 && cur_hc == 400) begin
          check("lock_on_3rd_vfall", bus.locked, 1);
          check("lock_frame_lines", bus.frame_lines, 5);
        end
      end
      1: begin
        if (cur_line == 2 && cur_hc == 143) check("hc143_inactive", bus.active, 0);
        if (cur_line == 2 && cur_hc == 144) begin
          check("first_px_active", bus.active, 1);
          check("first_px_x", bus.pix_x, 0);
          check("first_px_y", bus.pix_y, 0);
        end
        if (cur_line == 2 && cur_hc == 783) check("last_px_x", bus.pix_x, 639);
        if (cur_line == 2 && cur_hc == 784) check("hc784_inactive", bus.active, 0);
        if (cur_line == 3 && cur_hc == 200) begin
          check("line3_y", bus.pix_y, 1);
          check("line3_x", bus.pix_x, 56);
        end
        if (cur_line == 4 && cur_hc == 200) check("vend_inactive", bus.active, 0);
      end
      2: begin
        if (cur_line == 2 && cur_hc == 200) check("pre_err_locked", bus.locked, 1);
        if (cur_line == 3 && cur_hc == 0) begin
          check("long_line_len", bus.line_len, 801);
          check("long_line_herr", bus.h_err, 1);
          check("long_line_unlock", bus.locked, 0);
          check("long_line_active", bus.active, 0);
        end
        if (cur_line == 3 && cur_hc == 1) check("herr_one_cycle", bus.h_err, 0);
      end
      3: begin
        if (cur_line == 2 && cur_hc == 94) check("pre_rise_herr", bus.h_err, 0);
        if (cur_line == 2 && cur_hc == 95) begin
          check("narrow_sync_herr", bus.h_err, 1);
          check("narrow_sync_unlock", bus.locked, 0);
        end
      end
      4: begin
        if (cur_line == 0 && cur_hc == 400) begin
          check("short_frame_verr", bus.v_err, 1);
          check("short_frame_lines", bus.frame_lines, 4);
          check("short_frame_unlock", bus.locked, 0);
        end
        if (cur_line == 0 && cur_hc == 401) check("verr_one_cycle", bus.v_err, 0);
      end
      5: begin
        if (cur_line == 9 && cur_hc == 0) begin
          check("coinc_line_len", bus.line_len, 800);
          check("coinc_frame_lines", bus.frame_lines, 4);
          check("coinc_no_verr_search", bus.v_err, 0);
        end
      end
      6: begin
        if (cur_line == 0 && cur_hc == 400) begin
          check("after_coinc_lines", bus.frame_lines, 5);
          check("after_coinc_verr", bus.v_err, 0);
        end
      end
      7: begin
        if (cur_line == 20 && cur_hc == 2999) check("idle_line_len", bus.line_len, 800);
        if (cur_line == 21 && cur_hc == 0) begin
          check("sat_line_len", bus.line_len, 0);
          check("sat_herr", bus.h_err, 1);
        end
      end
      default: ;
    endcase
  endtask

  initial forever begin
    @(negedge clk_25);
    compare();
  end

  // Inputs change just after the falling edge, well clear of both sampling points.
  task automatic drive(input logic hs, input logic vs, input int line, input int hc);
    @(negedge clk_25);
    #1;
    bus.h_sync = hs;
    bus.v_sync = vs;
    cur_line = line;
    cur_hc = hc;
  endtask

  // vmode: 0 high, 1 falls at hc 400, 2 rises at hc 400, 3 low all line.
  task automatic drive_line(input int line, input int len, input int hsw, input int vmode);
    logic vs;
    for (int hc = 0; hc < len; hc++) begin
      case (vmode)
        1: vs = (hc < 400);
        2: vs = (hc >= 400);
        3: vs = 1'b0;
        default: vs = 1'b1;
      endcase
      drive(hc >= hsw, vs, line, hc);
    end
  endtask

  task automatic frame(input int nlines, input int bad_idx, input int bad_len, input int bad_hsw);
    for (int i = 0; i < nlines; i++)
      drive_line(i, (i == bad_idx) ? bad_len : H_TOTAL, (i == bad_idx) ? bad_hsw : H_SYNC,
                 (i == 0) ? 1 : (i == 1) ? 2 : 0);
  endtask

  initial begin
    bus.h_sync = 1'b1;
    bus.v_sync = 1'b1;
    for (int i = 0; i < 10; i++) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, i);
    check("rst_locked", bus.locked, 0);
    check("rst_line_len", bus.line_len, 0);
    check("rst_frame_lines", bus.frame_lines, 0);
    check("rst_h_err", bus.h_err, 0);

    drive(1'b1, 1'b1, -1, 0);
    #5 reset_n = 1'b1;
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, -1, i);
    check("idle_locked", bus.locked, 0);
    check("idle_line_len", bus.line_len, 0);

    frame(5, -1, 0, 0);
    frame(5, -1, 0, 0);
    probe = 8;
    frame(5, -1, 0, 0);
    probe = 0;
    check("nominal_locked", bus.locked, 1);
    check("nominal_line_len", bus.line_len, 800);
    check("nominal_frame_lines", bus.frame_lines, 5);

    probe = 1;
    frame(5, -1, 0, 0);
    probe = 2;
    frame(5, 2, 801, H_SYNC);
    probe = 0;
    for (int f = 0; f < 3; f++) frame(5, -1, 0, 0);
    check("relock_after_line_err", bus.locked, 1);

    probe = 3;
    frame(5, 2, H_TOTAL, 95);
    probe = 0;
    for (int f = 0; f < 3; f++) frame(5, -1, 0, 0);
    check("relock_after_sync_err", bus.locked, 1);

    frame(4, -1, 0, 0);
    probe = 4;
    frame(5, -1, 0, 0);

    probe = 5;
    drive_line(9, H_TOTAL, H_SYNC, 3);
    drive_line(10, H_TOTAL, H_SYNC, 2);
    for (int l = 11; l < 14; l++) drive_line(l, H_TOTAL, H_SYNC, 0);
    probe = 6;
    frame(5, -1, 0, 0);

    probe = 7;
    for (int i = 0; i < 3000; i++) drive(1'b1, 1'b1, 20, i);
    drive_line(21, H_TOTAL, H_SYNC, 0);
    probe = 0;
    drive_line(22, 300, H_SYNC, 0);
    check("pre_reset_line_len", bus.line_len, 800);

    #5 reset_n = 1'b0;
    #1;
    check("async_rst_line_len", bus.line_len, 0);
    check("async_rst_frame_lines", bus.frame_lines, 0);
    check("async_rst_locked", bus.locked, 0);
    #80;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
